// File: rtl/tt_pkg.sv
// tt_pkg: shared FSM states, default parameters and signature width for the truth-table sweeper
package tt_pkg;
    localparam int N_IN_DEF   = 4;
    localparam int N_OUT_DEF  = 2;
    localparam int SETTLE_DEF = 1;
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FIN} state_e;
    function automatic int sig_w(input int n_in, input int n_out);
        return n_out * (1 << n_in);
    endfunction
endpackage

// File: rtl/tt_sweep_if.sv
// tt_sweep_if: sweep request, pattern/response pins and result signals of tt_sweep
interface tt_sweep_if #(
    parameter int N_IN  = tt_pkg::N_IN_DEF,
    parameter int N_OUT = tt_pkg::N_OUT_DEF
);
    localparam int SW = tt_pkg::sig_w(N_IN, N_OUT);
    logic             start;
    logic [SW-1:0]    exp_sig;
    logic [N_IN-1:0]  pat_out;
    logic [N_OUT-1:0] resp_in;
    logic             busy;
    logic             done;
    logic [SW-1:0]    sig;
    logic             match;
    logic [N_IN-1:0]  fail_idx;
    modport master (output start, exp_sig, resp_in, input pat_out, busy, done, sig, match, fail_idx);
    modport slave  (input start, exp_sig, resp_in, output pat_out, busy, done, sig, match, fail_idx);
endinterface

// File: rtl/tt_cmp.sv
// tt_cmp: per-sample response mismatch detection with sticky first-fail index capture
module tt_cmp #(
    parameter int N_IN  = tt_pkg::N_IN_DEF,
    parameter int N_OUT = tt_pkg::N_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [N_IN-1:0]  p_i,
    input  logic [N_OUT-1:0] resp_i,
    input  logic [N_OUT-1:0] exp_i,
    output logic             fail_o,
    output logic [N_IN-1:0]  fail_idx_o
);
    logic            fail_q, fail_d, miss;
    logic [N_IN-1:0] idx_q, idx_d;
    always_comb begin
        miss   = en_i && (resp_i != exp_i);
        fail_d = clr_i ? 1'b0 : (fail_q | miss);
        idx_d  = clr_i ? '0 : (miss && !fail_q) ? p_i : idx_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            fail_q <= fail_d;
            idx_q  <= idx_d;
        end
    end
    assign fail_o     = fail_q;
    assign fail_idx_o = idx_q;
endmodule

// File: rtl/tt_sweep.sv
// tt_sweep: walks every input pattern of a circuit, holding each SETTLE+1 cycles,
// and records its responses into a truth-table signature checked against an expected one
module tt_sweep
    import tt_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input logic       clk,
    input logic       rst,
    tt_sweep_if.slave bus
);
    localparam int NP = 1 << N_IN;
    localparam int SW = sig_w(N_IN, N_OUT);
    localparam logic [N_IN-1:0] PMAX = {N_IN{1'b1}};
    state_e           state_q, state_d;
    logic [N_IN-1:0]  pat_q, pat_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, match_q, match_d;
    logic [SW-1:0]    sig_q, sig_d, exp_q, exp_d;
    logic [N_OUT-1:0] exp_bits;
    logic             accept, sample, fail;
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sig_d    = sig_q;
        exp_d    = exp_q;
        match_d  = match_q;
        accept   = 1'b0;
        sample   = 1'b0;
        exp_bits = '0;
        for (int j = 0; j < N_OUT; j++) exp_bits[j] = exp_q[j*NP + int'(pat_q)];
        case (state_q)
            IDLE: if (bus.start) begin
                accept  = 1'b1;
                exp_d   = bus.exp_sig;
                sig_d   = '0;
                pat_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
                match_d = 1'b0;
                state_d = (SETTLE == 0) ? SAMPLE : HOLD;
            end
            HOLD: begin
                cnt_d   = (cnt_q == 4'(SETTLE - 1)) ? 4'd0 : cnt_q + 4'd1;
                state_d = (cnt_q == 4'(SETTLE - 1)) ? SAMPLE : HOLD;
            end
            SAMPLE: begin
                sample = 1'b1;
                for (int j = 0; j < N_OUT; j++) sig_d[j*NP + int'(pat_q)] = bus.resp_in[j];
                pat_d   = (pat_q == PMAX) ? pat_q : pat_q + 1'b1;
                state_d = (pat_q == PMAX) ? FIN : (SETTLE == 0) ? SAMPLE : HOLD;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                match_d = !fail;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            sig_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
        end
    end
    tt_cmp #(.N_IN(N_IN), .N_OUT(N_OUT)) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .en_i       (sample),
        .p_i        (pat_q),
        .resp_i     (bus.resp_in),
        .exp_i      (exp_bits),
        .fail_o     (fail),
        .fail_idx_o (bus.fail_idx)
    );
    assign bus.pat_out = pat_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sig     = sig_q;
    assign bus.match   = match_q;
endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: three sweepers (SETTLE 1, 0, 3) against a modelled circuit, with directed and random sweeps
module tb_tt_sweep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int mode = 0;
    logic [31:0] tt = '0;
    int settle [3] = '{1, 0, 3};

    logic        start_v [3];
    logic [31:0] exp_v [3];
    logic [2:0]  done_v, busy_v, match_v;
    logic [3:0]  pat_v [3];
    logic [3:0]  fidx_v [3];
    logic [31:0] sig_v [3];

    tt_sweep_if #(.N_IN(4), .N_OUT(2)) if0 ();
    tt_sweep_if #(.N_IN(4), .N_OUT(2)) if1 ();
    tt_sweep_if #(.N_IN(4), .N_OUT(2)) if2 ();
    tt_sweep #(.N_IN(4), .N_OUT(2), .SETTLE(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    tt_sweep #(.N_IN(4), .N_OUT(2), .SETTLE(0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    tt_sweep #(.N_IN(4), .N_OUT(2), .SETTLE(3)) u2 (.clk(clk), .rst(rst), .bus(if2));

    // circuit under sweep: 0 = AND/OR of n0,n3; 1 = tied low; 2 = arbitrary table tt
    function automatic logic [1:0] circ(input logic [3:0] p, input int m, input logic [31:0] t);
        return (m == 0) ? {p[0] | p[3], p[0] & p[3]} : (m == 1) ? 2'b00 : {t[16 + int'(p)], t[int'(p)]};
    endfunction

    function automatic logic [31:0] model_sig(input int m, input logic [31:0] t);
        logic [31:0] s = '0;
        for (int p = 0; p < 16; p++) begin
            logic [1:0] r = circ(4'(p), m, t);
            s[p] = r[0];
            s[16 + p] = r[1];
        end
        return s;
    endfunction

    function automatic logic [3:0] model_fidx(input logic [31:0] s, input logic [31:0] e);
        for (int p = 0; p < 16; p++)
            if (s[p] != e[p] || s[16 + p] != e[16 + p]) return 4'(p);
        return 4'd0;
    endfunction

    assign if0.resp_in = circ(if0.pat_out, mode, tt);
    assign if1.resp_in = circ(if1.pat_out, mode, tt);
    assign if2.resp_in = circ(if2.pat_out, mode, tt);
    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if0.exp_sig = exp_v[0];
    assign if1.exp_sig = exp_v[1];
    assign if2.exp_sig = exp_v[2];
    assign done_v  = {if2.done, if1.done, if0.done};
    assign busy_v  = {if2.busy, if1.busy, if0.busy};
    assign match_v = {if2.match, if1.match, if0.match};
    assign pat_v[0] = if0.pat_out;
    assign pat_v[1] = if1.pat_out;
    assign pat_v[2] = if2.pat_out;
    assign fidx_v[0] = if0.fail_idx;
    assign fidx_v[1] = if1.fail_idx;
    assign fidx_v[2] = if2.fail_idx;
    assign sig_v[0] = if0.sig;
    assign sig_v[1] = if1.sig;
    assign sig_v[2] = if2.sig;

    // launch a sweep on instance k; lat = edges from accept to done (-1 on timeout),
    // perr = cycles where pat_out was not floor(c/(SETTLE+1)) capped at 15
    task automatic run(input int k, input logic [31:0] e, output int lat, output int perr);
        int ep;
        @(negedge clk);
        start_v[k] = 1'b1;
        exp_v[k] = e;
        @(posedge clk);
        #1 start_v[k] = 1'b0;
        lat = 0;
        perr = 0;
        while (!done_v[k] && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            ep = lat / (settle[k] + 1);
            if (ep > 15) ep = 15;
            if (pat_v[k] !== ep[3:0]) perr++;
        end
        if (!done_v[k]) lat = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if ({busy_v[k], done_v[k], match_v[k], pat_v[k], fidx_v[k], sig_v[k]} !== '0)
                $display("FAIL reset%0d: busy=%b done=%b match=%b pat=%h fidx=%h sig=%h want all 0", k, busy_v[k], done_v[k], match_v[k], pat_v[k], fidx_v[k], sig_v[k]);
            else passed++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy_v !== 3'b000) $display("FAIL idle_after_reset: busy=%b want 000", busy_v); else passed++;
    endtask

    task automatic test_andor();
        int lat, perr;
        logic [31:0] ms;
        mode = 0;
        ms = model_sig(0, tt);
        run(0, 32'hFFAA_AA00, lat, perr);
        checks++; if (lat !== 33) $display("FAIL andor_lat: got %0d want 33", lat); else passed++;
        checks++; if (perr !== 0) $display("FAIL andor_pat: %0d bad pattern cycles want 0", perr); else passed++;
        checks++; if (sig_v[0] !== ms || ms !== 32'hFFAA_AA00) $display("FAIL andor_sig: got %h want %h", sig_v[0], ms); else passed++;
        checks++; if (match_v[0] !== 1'b1) $display("FAIL andor_match: got %b want 1", match_v[0]); else passed++;
        checks++; if (fidx_v[0] !== 4'd0) $display("FAIL andor_fidx: got %0d want 0", fidx_v[0]); else passed++;
        checks++; if (busy_v[0] !== 1'b0) $display("FAIL andor_busy: got %b want 0", busy_v[0]); else passed++;
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b0) $display("FAIL andor_done_pulse: got %b want 0", done_v[0]); else passed++;
    endtask

    task automatic test_mismatch();
        int lat, perr;
        mode = 0;
        run(0, 32'hFFAA_AA01, lat, perr);
        checks++; if (match_v[0] !== 1'b0) $display("FAIL mis_lo_match: got %b want 0", match_v[0]); else passed++;
        checks++; if (fidx_v[0] !== 4'd0) $display("FAIL mis_lo_fidx: got %0d want 0", fidx_v[0]); else passed++;
        run(0, 32'hFFAA_2A00, lat, perr);
        checks++; if (match_v[0] !== 1'b0) $display("FAIL mis_hi_match: got %b want 0", match_v[0]); else passed++;
        checks++; if (fidx_v[0] !== 4'd15) $display("FAIL mis_hi_fidx: got %0d want 15", fidx_v[0]); else passed++;
        repeat (6) @(negedge clk);
        checks++; if ({sig_v[0], match_v[0], fidx_v[0], pat_v[0]} !== {32'hFFAA_AA00, 1'b0, 4'd15, 4'd15})
            $display("FAIL idle_hold: sig=%h match=%b fidx=%0d pat=%0d want ffaaaa00/0/15/15", sig_v[0], match_v[0], fidx_v[0], pat_v[0]);
        else passed++;
    endtask

    task automatic test_settle();
        int lat, perr;
        mode = 0;
        run(1, 32'hFFAA_AA00, lat, perr);
        checks++; if (lat !== 17) $display("FAIL s0_lat: got %0d want 17", lat); else passed++;
        checks++; if (perr !== 0) $display("FAIL s0_pat: %0d bad pattern cycles want 0", perr); else passed++;
        checks++; if (sig_v[1] !== 32'hFFAA_AA00 || match_v[1] !== 1'b1) $display("FAIL s0_sig: got %h/%b want ffaaaa00/1", sig_v[1], match_v[1]); else passed++;
        run(2, 32'hFFAA_AA00, lat, perr);
        checks++; if (lat !== 65) $display("FAIL s3_lat: got %0d want 65", lat); else passed++;
        checks++; if (perr !== 0) $display("FAIL s3_pat: %0d bad pattern cycles want 0", perr); else passed++;
        checks++; if (sig_v[2] !== 32'hFFAA_AA00 || match_v[2] !== 1'b1) $display("FAIL s3_sig: got %h/%b want ffaaaa00/1", sig_v[2], match_v[2]); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, perr;
        mode = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        exp_v[0] = 32'hFFAA_AA01;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy_v[0], done_v[0], match_v[0], pat_v[0], fidx_v[0], sig_v[0]} !== '0)
            $display("FAIL mid_reset: busy=%b done=%b match=%b pat=%h fidx=%h sig=%h want all 0", busy_v[0], done_v[0], match_v[0], pat_v[0], fidx_v[0], sig_v[0]);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (busy_v[0] !== 1'b0 || pat_v[0] !== 4'd0) $display("FAIL no_resume: busy=%b pat=%0d want 0/0", busy_v[0], pat_v[0]); else passed++;
        run(0, 32'hFFAA_AA00, lat, perr);
        checks++; if (lat !== 33 || sig_v[0] !== 32'hFFAA_AA00 || match_v[0] !== 1'b1)
            $display("FAIL after_reset_sweep: lat=%0d sig=%h match=%b want 33/ffaaaa00/1", lat, sig_v[0], match_v[0]);
        else passed++;
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int first = -1;
        mode = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        exp_v[0] = 32'hFFAA_AA00;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[0]) begin
                ndone++;
                if (first < 0) first = c;
            end
            start_v[0] = (c == 5 || c == 20);
        end
        checks++; if (ndone !== 1 || first !== 33) $display("FAIL ignore_start: dones=%0d first=%0d want 1/33", ndone, first); else passed++;
    endtask

    task automatic test_back_to_back();
        int edges[$];
        int w = 0;
        mode = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        exp_v[0] = 32'hFFAA_AA00;
        @(posedge clk);
        for (int c = 1; c <= 110; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[0]) edges.push_back(c);
        end
        start_v[0] = 1'b0;
        checks++;
        if (edges.size() != 3) $display("FAIL b2b_count: got %0d dones want 3", edges.size());
        else if (edges[0] != 33 || edges[1] - edges[0] != 34 || edges[2] - edges[1] != 34)
            $display("FAIL b2b_spacing: got %0d,%0d,%0d want 33,67,101", edges[0], edges[1], edges[2]);
        else passed++;
        while (!done_v[0] && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++; if (!done_v[0] || match_v[0] !== 1'b1) $display("FAIL b2b_drain: done=%b match=%b want 1/1", done_v[0], match_v[0]); else passed++;
    endtask

    task automatic test_zero();
        int lat, perr;
        mode = 1;
        run(0, 32'h0, lat, perr);
        checks++; if ({sig_v[0], match_v[0], fidx_v[0]} !== {32'h0, 1'b1, 4'd0})
            $display("FAIL zero: sig=%h match=%b fidx=%0d want 0/1/0", sig_v[0], match_v[0], fidx_v[0]);
        else passed++;
    endtask

    task automatic test_random();
        int lat, perr, k;
        logic [31:0] e, ms;
        mode = 2;
        for (int i = 0; i < 10; i++) begin
            k = $urandom_range(0, 2);
            tt = $urandom;
            e = tt;
            if ($urandom_range(0, 2) != 0) e[$urandom_range(0, 31)] ^= 1'b1;
            if ($urandom_range(0, 1) != 0) e[$urandom_range(0, 31)] ^= 1'b1;
            ms = model_sig(2, tt);
            run(k, e, lat, perr);
            checks++;
            if (lat !== 16 * (settle[k] + 1) + 1 || perr !== 0 || sig_v[k] !== ms || match_v[k] !== (e == ms) || fidx_v[k] !== model_fidx(ms, e))
                $display("FAIL rand%0d u%0d: lat=%0d perr=%0d sig=%h match=%b fidx=%0d want lat=%0d sig=%h match=%b fidx=%0d",
                         i, k, lat, perr, sig_v[k], match_v[k], fidx_v[k], 16 * (settle[k] + 1) + 1, ms, e == ms, model_fidx(ms, e));
            else passed++;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            exp_v[k] = '0;
        end
        test_reset();
        test_andor();
        test_mismatch();
        test_settle();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        test_zero();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning the number of pattern bits driven to the circuit under sweep.
REQ-002 SHALL have parameter N_OUT, default 2, meaning the number of response bits captured from the circuit under sweep.
REQ-003 SHALL have parameter SETTLE, default 1, range 0..15, meaning extra hold cycles per pattern before sampling.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  sweep request, sampled while idle.
REQ-007 SHALL have port exp_sig  input  N_OUT*2^N_IN  expected signature, captured when start is accepted.
REQ-008 SHALL have port pat_out  output  N_IN  pattern to the circuit inputs; bit i drives input n<i>.
REQ-009 SHALL have port resp_in  input  N_OUT  responses from the circuit outputs; bit j is output j in declaration order.
REQ-010 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-012 SHALL have port sig  output  N_OUT*2^N_IN  captured truth-table signature.
REQ-013 SHALL have port match  output  1  sig equals captured exp_sig; valid from done until the next accepted start.
REQ-014 SHALL have port fail_idx  output  N_IN  lowest pattern index with any mismatching response bit; 0 when match=1.

Function
REQ-015 SHALL implement FSM states IDLE, HOLD, SAMPLE and FIN.
REQ-016 SHALL, in IDLE with start=1, capture exp_sig, clear sig, set pat_out=0 and the hold counter to 0, raise busy and enter HOLD on the next edge.
REQ-017 SHALL keep pat_out constant for SETTLE+1 cycles per pattern: HOLD counts SETTLE cycles, then SAMPLE lasts one cycle; with SETTLE=0 the FSM goes directly to SAMPLE.
REQ-018 SHALL, on the SAMPLE edge, write sig[j*2^N_IN + p] = resp_in[j] for every j, where p is the current pat_out.
REQ-019 SHALL, on the SAMPLE edge, set fail_idx=p and a sticky fail flag if resp_in differs from the matching exp_sig bits and the fail flag is still clear.
REQ-020 SHALL, on the SAMPLE edge with p < 2^N_IN-1, increment pat_out and return to HOLD (or remain in SAMPLE when SETTLE=0).
REQ-021 SHALL, on the SAMPLE edge with p = 2^N_IN-1, enter FIN.
REQ-022 SHALL, in FIN, assert done for one cycle, drop busy, drive match = NOT fail flag, and return to IDLE.
REQ-023 SHALL make done occur exactly 2^N_IN*(SETTLE+1)+1 cycles after the start-accept edge: 33 cycles with defaults.
REQ-024 SHALL ignore start while busy or in FIN; start held high in IDLE re-launches a sweep immediately after done.
REQ-025 SHALL hold sig, match and fail_idx stable in IDLE until the next accepted start.
REQ-026 SHALL hold pat_out at 2^N_IN-1 after completion; pat_out does not wrap to 0.

Reset
REQ-027 SHALL, on rst=1 at any time (including mid-sweep), immediately force state=IDLE, pat_out=0, busy=0, done=0, sig=0, match=0, fail_idx=0, fail flag=0, hold counter=0 and captured exp_sig=0.
REQ-028 SHALL require a new start after rst deasserts; an interrupted sweep is not resumed.

Structure
REQ-029 SHALL place the FSM state enum, the default parameter values and the signature-width expression N_OUT*2^N_IN in a shared package, tt_pkg.
REQ-030 SHALL keep the sweep controller as a single module; one sub-module, tt_cmp, is permitted for per-sample mismatch detection and first-fail capture.

Verification
REQ-031 SHALL cover: defaults, resp_in[0]=pat[0]&pat[3], resp_in[1]=pat[0]|pat[3], exp_sig=32'hFFAA_AA00, start pulse -> done at cycle 33, sig=32'hFFAA_AA00, match=1, fail_idx=0.
REQ-032 SHALL cover: same circuit with exp_sig=32'hFFAA_AA01 -> match=0, fail_idx=0; with exp_sig=32'hFFAA_2A00 -> match=0, fail_idx=15.
REQ-033 SHALL cover: SETTLE=0 -> pat_out advances every cycle, done at cycle 17; SETTLE=3 -> each pattern held 4 cycles, done at cycle 65.
REQ-034 SHALL cover: rst asserted at cycle 10 of a sweep -> same-cycle outputs all 0, state IDLE; a following start yields a full 33-cycle sweep with the correct sig.
REQ-035 SHALL cover: start pulses at cycles 5 and 20 of a sweep -> ignored, exactly one done; start held high continuously -> back-to-back sweeps, with done every 34 cycles.
REQ-036 SHALL cover: resp_in tied to 2'b00 with exp_sig=0 -> sig=0, match=1, fail_idx=0.
